// File: rtl/bayesian_coord_unit_if.sv
// Handshake and data bundle between triangle setup, the barycentric unit and the interpolator.
interface bayesian_coord_unit_if;
    logic               nd;
    logic               us_rfd;
    logic signed [15:0] v1_x, v1_y, v2_x, v2_y, v3_x, v3_y;
    logic signed [15:0] p_x, p_y;
    logic               ds_rfd;
    logic               rdy;
    logic        [15:0] b_u, b_v, b_w;

    modport slave (
        input  nd, v1_x, v1_y, v2_x, v2_y, v3_x, v3_y, p_x, p_y, ds_rfd,
        output us_rfd, rdy, b_u, b_v, b_w
    );
    modport master (
        output nd, v1_x, v1_y, v2_x, v2_y, v3_x, v3_y, p_x, p_y, ds_rfd,
        input  us_rfd, rdy, b_u, b_v, b_w
    );
endinterface

// File: rtl/bayesian_coord_unit.sv
// Barycentric weights (Q2.14) of point P in triangle V1-V2-V3 via edge functions
// and two parallel 16-step restoring dividers; one job in flight at a time.
module bayesian_coord_unit (
    input  logic                 clk,
    input  logic                 rst,
    bayesian_coord_unit_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_DELTA, S_CROSS, S_DIV, S_DONE} state_t;

    state_t             r_state, w_next;
    logic        [4:0]  r_cnt;
    logic signed [15:0] r_v1x, r_v1y, r_v2x, r_v2y, r_v3x, r_v3y, r_px, r_py;
    logic signed [16:0] r_d [12];
    logic        [34:0] r_den;
    logic               r_degen;
    logic               r_neg [2];
    logic               r_sat [2];
    logic        [35:0] r_rem [2];
    logic        [15:0] r_xlo [2];
    logic        [15:0] r_q   [2];
    logic        [15:0] r_bu, r_bv, r_bw;

    logic signed [34:0] w_e   [3];
    logic        [34:0] w_abs [3];
    logic        [35:0] w_sh  [2];
    logic               w_ge  [2];
    logic        [15:0] w_uv  [2];
    logic signed [17:0] w_w18;
    logic        [15:0] w_w;

    function automatic logic signed [34:0] edge_fn(input logic signed [16:0] bax, cay, bay, cax);
        logic signed [33:0] p0, p1;
        p0 = bax * cay;
        p1 = bay * cax;
        return {p0[33], p0} - {p1[33], p1};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.nd) w_next = S_DELTA;
            S_DELTA: w_next = S_CROSS;
            S_CROSS: w_next = S_DIV;
            S_DIV:   if (r_cnt == 5'd16) w_next = S_DONE;
            S_DONE:  if (bus.ds_rfd) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.us_rfd = (r_state == S_IDLE);
        bus.rdy    = (r_state == S_DONE);
        bus.b_u    = r_bu;
        bus.b_v    = r_bv;
        bus.b_w    = r_bw;
    end

    // Index 0 = area A, 1 = Eu (V2,V3,P), 2 = Ev (V3,V1,P)
    always_comb begin
        w_e[0] = edge_fn(r_d[0], r_d[1], r_d[2],  r_d[3]);
        w_e[1] = edge_fn(r_d[4], r_d[5], r_d[6],  r_d[7]);
        w_e[2] = edge_fn(r_d[8], r_d[9], r_d[10], r_d[11]);
        for (int k = 0; k < 3; k++)
            w_abs[k] = w_e[k][34] ? 35'(-w_e[k]) : 35'(w_e[k]);
    end

    // Dividend is |E|<<14; its top part seeds the remainder, the low 16 bits shift in.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_sh[k] = {r_rem[k][34:0], r_xlo[k][15]};
            w_ge[k] = (w_sh[k] >= {1'b0, r_den});
            if (r_sat[k])      w_uv[k] = r_neg[k] ? 16'h8000 : 16'h7FFF;
            else if (r_neg[k]) w_uv[k] = 16'(-r_q[k]);
            else               w_uv[k] = r_q[k];
        end
        w_w18 = 18'sh04000 - {{2{w_uv[0][15]}}, w_uv[0]} - {{2{w_uv[1][15]}}, w_uv[1]};
        if (w_w18 > 18'sh07FFF)       w_w = 16'h7FFF;
        else if (w_w18 < -18'sh08000) w_w = 16'h8000;
        else                          w_w = w_w18[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_bu  <= '0;
            r_bv  <= '0;
            r_bw  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.nd) begin
                    r_v1x <= bus.v1_x; r_v1y <= bus.v1_y;
                    r_v2x <= bus.v2_x; r_v2y <= bus.v2_y;
                    r_v3x <= bus.v3_x; r_v3y <= bus.v3_y;
                    r_px  <= bus.p_x;  r_py  <= bus.p_y;
                end
                S_DELTA: begin
                    r_d[0]  <= 17'(r_v2x) - 17'(r_v1x);
                    r_d[1]  <= 17'(r_v3y) - 17'(r_v1y);
                    r_d[2]  <= 17'(r_v2y) - 17'(r_v1y);
                    r_d[3]  <= 17'(r_v3x) - 17'(r_v1x);
                    r_d[4]  <= 17'(r_v3x) - 17'(r_v2x);
                    r_d[5]  <= 17'(r_py)  - 17'(r_v2y);
                    r_d[6]  <= 17'(r_v3y) - 17'(r_v2y);
                    r_d[7]  <= 17'(r_px)  - 17'(r_v2x);
                    r_d[8]  <= 17'(r_v1x) - 17'(r_v3x);
                    r_d[9]  <= 17'(r_py)  - 17'(r_v3y);
                    r_d[10] <= 17'(r_v1y) - 17'(r_v3y);
                    r_d[11] <= 17'(r_px)  - 17'(r_v3x);
                end
                S_CROSS: begin
                    r_cnt   <= '0;
                    r_den   <= w_abs[0];
                    r_degen <= (w_e[0] == '0);
                    for (int k = 0; k < 2; k++) begin
                        r_neg[k] <= w_e[k+1][34] ^ w_e[0][34];
                        r_sat[k] <= ({1'b0, w_abs[k+1]} >= {w_abs[0], 1'b0});
                        r_rem[k] <= {3'b000, w_abs[k+1][34:2]};
                        r_xlo[k] <= {w_abs[k+1][1:0], 14'b0};
                        r_q[k]   <= '0;
                    end
                end
                S_DIV: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt != 5'd16) begin
                        for (int k = 0; k < 2; k++) begin
                            r_rem[k] <= w_ge[k] ? w_sh[k] - {1'b0, r_den} : w_sh[k];
                            r_q[k]   <= {r_q[k][14:0], w_ge[k]};
                            r_xlo[k] <= {r_xlo[k][14:0], 1'b0};
                        end
                    end else begin
                        r_bu <= r_degen ? 16'h0000 : w_uv[0];
                        r_bv <= r_degen ? 16'h0000 : w_uv[1];
                        r_bw <= r_degen ? 16'h0000 : w_w;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bayesian_coord_unit.sv
// Directed-vector bench for bayesian_coord_unit with hand-computed weights.
`timescale 1ns/1ps
module tb_bayesian_coord_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    bayesian_coord_unit_if bus();
    bayesian_coord_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int x1, y1, x2, y2, x3, y3, px, py);
        bus.v1_x = 16'(x1); bus.v1_y = 16'(y1);
        bus.v2_x = 16'(x2); bus.v2_y = 16'(y2);
        bus.v3_x = 16'(x3); bus.v3_y = 16'(y3);
        bus.p_x  = 16'(px); bus.p_y  = 16'(py);
    endtask

    // Called right after a negedge; hold = cycles ds_rfd stays low once rdy is up.
    task automatic run_job(input string tag, input int x1, y1, x2, y2, x3, y3, px, py,
                           input logic [15:0] eu, ev, ew, input int hold, input bit scramble);
        int n;
        chk({tag, "_idle_rfd"}, 64'(bus.us_rfd), 64'd1);
        set_in(x1, y1, x2, y2, x3, y3, px, py);
        bus.ds_rfd = (hold == 0);
        bus.nd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.nd = 1'b0;
        chk({tag, "_busy_rfd"}, 64'(bus.us_rfd), 64'd0);
        n = 1;
        while (!bus.rdy && n < 40) begin
            @(negedge clk);
            n++;
            if (scramble && n == 8) begin
                set_in(100, -7, 3, 9, -50, 11, 2, 2);
                bus.nd = 1'b1;
            end
            if (scramble && n == 9) bus.nd = 1'b0;
        end
        chk({tag, "_lat"}, 64'(n), 64'd20);
        chk({tag, "_uvw"}, {16'h0, bus.b_u, bus.b_v, bus.b_w}, {16'h0, eu, ev, ew});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold"}, {14'h0, bus.rdy, bus.us_rfd, bus.b_u, bus.b_v, bus.b_w},
                {14'h0, 1'b1, 1'b0, eu, ev, ew});
        end
        bus.ds_rfd = 1'b1;
        @(negedge clk);
        chk({tag, "_rel"}, {14'h0, bus.rdy, bus.us_rfd, bus.b_u, bus.b_v, bus.b_w},
            {14'h0, 1'b0, 1'b1, eu, ev, ew});
    endtask

    initial begin
        bus.nd = 1'b0;
        bus.ds_rfd = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset", {15'h0, bus.us_rfd, bus.rdy, bus.b_u, bus.b_v, bus.b_w},
            {15'h0, 1'b1, 1'b0, 48'h0});

        run_job("nominal", 0, 0, 4, 0, 0, 4, 1, 1,   16'h2000, 16'h1000, 16'h1000, 0, 1'b0);
        run_job("vertex",  0, 0, 4, 0, 0, 4, 0, 0,   16'h4000, 16'h0000, 16'h0000, 0, 1'b0);
        run_job("winding", 0, 0, 0, 4, 4, 0, 1, 1,   16'h2000, 16'h1000, 16'h1000, 0, 1'b0);
        run_job("outside", 0, 0, 4, 0, 0, 4, 6, 0,   16'hE000, 16'h6000, 16'h0000, 0, 1'b0);
        run_job("sat",     0, 0, 4, 0, 0, 4, -4, 0,  16'h7FFF, 16'hC000, 16'h0001, 0, 1'b0);
        run_job("degen",   0, 0, 1, 1, 2, 2, 5, -3,  16'h0000, 16'h0000, 16'h0000, 0, 1'b0);
        run_job("third",   0, 0, 3, 0, 0, 3, 1, 1,   16'h1555, 16'h1555, 16'h1556, 0, 1'b0);
        run_job("trunc",   0, 0, 3, 0, 0, 3, -1, 1,  16'h4000, 16'hEAAB, 16'h1555, 0, 1'b0);
        run_job("stall",   0, 0, 4, 0, 0, 4, 1, 1,   16'h2000, 16'h1000, 16'h1000, 10, 1'b0);
        run_job("scram",   0, 0, 4, 0, 0, 4, 6, 0,   16'hE000, 16'h6000, 16'h0000, 0, 1'b1);

        // Abort a job mid-division
        set_in(0, 0, 4, 0, 0, 4, 1, 1);
        bus.nd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.nd = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_div", {15'h0, bus.us_rfd, bus.rdy, bus.b_u, bus.b_v, bus.b_w},
            {15'h0, 1'b1, 1'b0, 48'h0});
        rst = 1'b0;
        @(negedge clk);
        run_job("recover", 0, 0, 4, 0, 0, 4, 0, 0, 16'h4000, 16'h0000, 16'h0000, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bayesian_coord_unit.md
# bayesian_coord_unit

Computes the barycentric (area-ratio) coordinates of a pixel point P relative to a screen-space triangle V1-V2-V3. It sits in the pixel pipeline's triangle rasterizer, between pixel/triangle setup upstream and attribute interpolation downstream. Upstream and downstream are decoupled by ready-for-data handshakes. Processing is one point at a time over a fixed-latency iterative datapath.

## Interface
- No parameters; all widths fixed.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `nd` in 1: new data; qualifies vertex and point inputs.
- `us_rfd` out 1: upstream ready-for-data; a job is accepted on an edge where `nd` and `us_rfd` are both 1.
- `v1_x`, `v1_y`, `v2_x`, `v2_y`, `v3_x`, `v3_y` in 16 each: vertex coordinates, signed two's complement integers.
- `p_x`, `p_y` in 16 each: point coordinates, signed two's complement integers.
- `ds_rfd` in 1: downstream ready-for-data.
- `rdy` out 1: results valid.
- `b_u`, `b_v`, `b_w` out 16 each: weights of V1, V2 and V3, signed Q2.14, where 0x4000 = 1.0.

## Operation
- Edge function: E(a,b,c) = (b.x−a.x)(c.y−a.y) − (b.y−a.y)(c.x−a.x).
- Arithmetic widths:
  - Differences are 17-bit signed.
  - Products are 34-bit signed.
  - E is 35-bit signed and exact; no overflow is possible.
- Area: A = E(V1,V2,V3).
- Edge terms: Eu = E(V2,V3,P) and Ev = E(V3,V1,P). Either winding order gives the same weights.
- Weight definitions:
  - u = Eu/A and v = Ev/A.
  - Each is computed as sign-magnitude: quotient = floor(|E|·2^14 / |A|), then negated if sign(E) ≠ sign(A). This truncates toward zero.
- Saturation: if |E| ≥ 2·|A|, the magnitude result saturates. The output is 0x7FFF if positive, 0x8000 if negative; no division is needed in that case.
- Dividers: two restoring dividers (u, v) run in parallel, each producing 1 quotient bit per cycle for 16 iterations.
- w = 0x4000 − u − v, computed in 18-bit signed and then saturated to [−32768, 32767].
- Degenerate triangle (A = 0): `b_u`, `b_v` and `b_w` are all 0x0000, with normal latency and handshake.
- All inputs are captured in internal registers on the accept edge. Later input changes do not affect the job in flight.
- State machine:
  - IDLE (`us_rfd`=1): on `nd`=1 capture the inputs and go to DELTA.
  - DELTA: compute differences; go to CROSS.
  - CROSS: compute A, Eu and Ev, run the saturation check; go to DIV.
  - DIV: 16 cycles of iteration; go to DONE.
  - DONE (`rdy`=1): when `ds_rfd`=1, go to IDLE.
- `nd` is ignored outside IDLE.

## Timing
- Reset values: `us_rfd`=1, `rdy`=0, `b_u`/`b_v`/`b_w`=0x0000, state=IDLE.
- Reset mid-operation aborts the current job with no output; the block is in IDLE the cycle after reset deasserts.
- `us_rfd` drops on the cycle after the accept edge (edge T).
- Latency: `rdy` and the outputs become valid after edge T+19 (DELTA at T+1, CROSS at T+2, DIV at T+3..T+18, DONE registered at T+19).
- Outputs are registered and stay stable while `rdy`=1.
- Release: `rdy` holds until an edge where `rdy`=1 and `ds_rfd`=1. `rdy` falls after that edge, and `us_rfd` rises after the same edge.
- If `ds_rfd` is already 1 when `rdy` rises, the result is released on the first edge where `rdy`=1, so `rdy` is high for exactly one cycle.
- Outputs keep their last value after release.
- Minimum initiation interval: 21 cycles. `nd` held high continuously results in back-to-back jobs at that interval.

## Test plan
- Nominal: V1=(0,0), V2=(4,0), V3=(0,4), P=(1,1) -> `b_u`=0x2000, `b_v`=0x1000, `b_w`=0x1000; `rdy` rises 20 edges after accept.
- Vertex and winding: same triangle with P=(0,0) -> 0x4000/0x0000/0x0000. Swapping V2 and V3 with P=(1,1) -> `b_u`=0x2000, `b_v`=0x1000 (now the weight of (0,4)), `b_w`=0x1000.
- Outside point: same triangle, P=(6,0) -> `b_u`=0xE000, `b_v`=0x6000, `b_w`=0x0000.
- Saturation: same triangle, P=(−4,0) -> `b_u`=0x7FFF, `b_v`=0xC000, `b_w`=0x0001.
- Degenerate: collinear vertices (0,0), (1,1), (2,2), any P -> all outputs 0x0000 with `rdy` asserted.
- Handshake and reset:
  - Hold `ds_rfd`=0 for 10 cycles after `rdy` -> `rdy` and outputs stay stable and `us_rfd` stays 0.
  - Input changes during DIV have no effect on the result.
  - `rst` during DIV -> next cycle `rdy`=0, `us_rfd`=1, outputs 0x0000.
